// File: rtl/piso_4bit_tx.sv
// Parallel-in serial-out transmitter feeding the SIPO receive stage.
// One word per valid/ready handshake, one bit per clk, optional idle gap between words.
module piso_4bit_tx #(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             pin_valid,
  output logic             pin_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a word, pin_ready=1
  // SHIFT | emitting word bits, sout_valid=1, sof on bit 0
  // GAP   | forced idle line for GAP_CYCLES cycles before next word

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit BACK2BACK = (GAP_CYCLES == 0);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("piso_4bit_tx: WIDTH out of range 2..16");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("piso_4bit_tx: GAP_CYCLES out of range 0..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, nxt_state;
  logic [WIDTH-1:0] sr, nxt_sr, sr_adv;
  logic [CW-1:0]    bit_cnt, nxt_bit_cnt;
  logic [3:0]       gap_cnt, nxt_gap_cnt;
  logic             accept;
  logic             nxt_sout, nxt_sout_valid, nxt_sof, nxt_busy, nxt_ready;

  // pin_ready is registered, so the handshake never depends combinationally on pin_valid
  assign accept = pin_valid & pin_ready;
  assign sr_adv = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

  always_comb begin
    nxt_state   = state;
    nxt_sr      = sr;
    nxt_bit_cnt = bit_cnt;
    nxt_gap_cnt = gap_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          nxt_state   = SHIFT;
          nxt_sr      = pin;
          nxt_bit_cnt = '0;
        end
      end
      SHIFT: begin
        nxt_sr      = sr_adv;
        nxt_bit_cnt = bit_cnt + 1'b1;
        if (bit_cnt == LAST) begin
          nxt_bit_cnt = '0;
          if (!BACK2BACK) begin
            nxt_state   = GAP;
            nxt_gap_cnt = GAP_LOAD;
          end else if (accept) begin
            nxt_sr = pin;
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          nxt_state = IDLE;
        end else begin
          nxt_gap_cnt = gap_cnt - 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they come straight off flops
  always_comb begin
    nxt_sout_valid = (nxt_state == SHIFT);
    nxt_sout       = (nxt_state == SHIFT) &&
                     ((MSB_FIRST != 0) ? nxt_sr[WIDTH-1] : nxt_sr[0]);
    nxt_sof        = (nxt_state == SHIFT) && (nxt_bit_cnt == '0);
    nxt_busy       = (nxt_state != IDLE);
    nxt_ready      = (nxt_state == IDLE) ||
                     (BACK2BACK && (nxt_state == SHIFT) && (nxt_bit_cnt == LAST));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sof        <= 1'b0;
      busy       <= 1'b0;
      pin_ready  <= 1'b1;
    end else begin
      state      <= nxt_state;
      sr         <= nxt_sr;
      bit_cnt    <= nxt_bit_cnt;
      gap_cnt    <= nxt_gap_cnt;
      sout       <= nxt_sout;
      sout_valid <= nxt_sout_valid;
      sof        <= nxt_sof;
      busy       <= nxt_busy;
      pin_ready  <= nxt_ready;
    end
  end

endmodule

// File: tb/tb_piso_4bit_tx.sv
// Scoreboard bench for piso_4bit_tx: four configurations driven in parallel,
// expected bit streams queued at acceptance and popped whenever sout_valid is seen.
module tb_piso_4bit_tx;

  localparam int N = 4;
  localparam int W_P   [N] = '{4, 4, 4, 7};
  localparam int MSB_P [N] = '{1, 1, 0, 1};
  localparam int GAP_P [N] = '{1, 0, 1, 3};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [N];
  logic        pv   [N];
  logic [15:0] pin  [N];
  logic        rdy  [N];
  logic        so   [N];
  logic        sv   [N];
  logic        sf   [N];
  logic        bz   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    piso_4bit_tx #(
      .WIDTH(W_P[g]),
      .MSB_FIRST(MSB_P[g]),
      .GAP_CYCLES(GAP_P[g])
    ) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .pin(pin[g][W_P[g]-1:0]),
      .pin_valid(pv[g]),
      .pin_ready(rdy[g]),
      .sout(so[g]),
      .sout_valid(sv[g]),
      .sof(sf[g]),
      .busy(bz[g])
    );
  end

  typedef struct packed {
    logic b;
    logic s;
  } ent_t;

  ent_t expq [N][$];
  int   rem  [N];
  bit   mon_en = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", nm, i, $time, act, exp);
  endtask

  // Reference model: rem counts the cycles a word occupies (WIDTH bits + gap);
  // a word is taken when the line is free, or on the last bit when there is no gap.
  initial begin
    for (int i = 0; i < N; i++) rem[i] = 0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        bit rdy_m;
        rdy_m = (rem[i] == 0) || (GAP_P[i] == 0 && rem[i] == 1);
        if (!rst[i]) begin
          expq[i].delete();
          rem[i] = 0;
        end else begin
          if (rem[i] > 0) rem[i]--;
          if (pv[i] && rdy_m) begin
            for (int b = 0; b < W_P[i]; b++) begin
              ent_t e;
              e.b = pin[i][(MSB_P[i] != 0) ? (W_P[i] - 1 - b) : b];
              e.s = (b == 0);
              expq[i].push_back(e);
            end
            rem[i] = W_P[i] + GAP_P[i];
          end
        end
      end
      mon_en = 1'b1;
    end
  end

  // Monitor: compares handshake/status every cycle, pops the scoreboard on each valid bit
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < N; i++) begin
          chk("sout_valid", i, sv[i], rem[i] > GAP_P[i]);
          chk("busy", i, bz[i], rem[i] > 0);
          chk("pin_ready", i, rdy[i], (rem[i] == 0) || (GAP_P[i] == 0 && rem[i] == 1));
          if (sv[i] === 1'b1) begin
            if (expq[i].size() == 0) begin
              n_chk++;
              $display("FAIL extra_bit inst%0d t=%0t actual=sout_valid=1 required=no pending bit", i, $time);
            end else begin
              ent_t e;
              e = expq[i].pop_front();
              chk("sout", i, so[i], e.b);
              chk("sof", i, sf[i], e.s);
            end
          end else begin
            chk("idle_sout", i, so[i], 0);
            chk("idle_sof", i, sf[i], 0);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset held with a word offered on every instance
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0;
      pv[i]  = 1'b1;
      pin[i] = 16'h000F;
    end
    cyc(2);
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      pv[i]  = 1'b0;
    end
    cyc(1);

    // default config, MSB first with one gap cycle
    pin[0] = 16'hA; pv[0] = 1'b1; cyc(1); pv[0] = 1'b0; cyc(6);

    // no gap: second word taken on the last bit of the first
    pin[1] = 16'hC; pv[1] = 1'b1; cyc(1);
    pin[1] = 16'h3; cyc(4); pv[1] = 1'b0; cyc(6);

    // LSB first
    pin[2] = 16'h1; pv[2] = 1'b1; cyc(1); pv[2] = 1'b0; cyc(6);

    // reset after two bits, then a clean frame
    pin[0] = 16'hF; pv[0] = 1'b1; cyc(1); pv[0] = 1'b0; cyc(1);
    rst[0] = 1'b0; cyc(1); rst[0] = 1'b1; cyc(1);
    pin[0] = 16'h6; pv[0] = 1'b1; cyc(1); pv[0] = 1'b0; cyc(6);

    // offer while shifting, then withdraw before ready
    pin[0] = 16'h9; pv[0] = 1'b1; cyc(1);
    pin[0] = 16'h5; cyc(2); pv[0] = 1'b0; cyc(8);

    // 7-bit, 3-gap instance with back-to-back offers
    pin[3] = 16'h55; pv[3] = 1'b1; cyc(1);
    pin[3] = 16'h0B; cyc(12); pv[3] = 1'b0; cyc(12);

    // randomized traffic with occasional reset on every instance
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        rst[i] = ($urandom_range(0, 99) != 0);
        pv[i]  = ($urandom_range(0, 2) != 0);
        pin[i] = 16'($urandom);
      end
      cyc(1);
    end

    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      pv[i]  = 1'b0;
    end
    cyc(30);
    @(negedge clk);
    for (int i = 0; i < N; i++) chk("queue_drained", i, expq[i].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
